gencon: RTL and testbench
=========================

Name: gencon

Overview:
- Sequential controller for a 16-bit signed keypad calculator.
- Accepts decimal digit keypresses for operand A, one operator (add/sub/mul), decimal digits for operand B, then an equals press.
- Computes the two's-complement result, asserts complete, and drives the display register.
- Sits between the keypad/button debouncers and the display driver.

Parameters:
- WIDTH, 16, operand/result width in bits; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- nRST  input  1  reset, synchronous, active-high; 1 = reset at the next rising clk.
- keypad_input  input  4  BCD digit code; valid digits are 0-9.
- read_input  input  1  digit strobe; keypad_input is sampled on its rising edge.
- operator_input  input  3  one-hot operator: 001 add, 010 subtract, 100 multiply.
- equal_input  input  1  equals button, level; acted on at its rising edge.
- complete  output  1  result valid; held high in DONE.
- display_output  output  WIDTH  current operand during entry, result after completion; two's complement.

Behaviour:
- Edge detection: registered copies of read_input, operator_input (OR of bits) and equal_input. A "press" is input high while its registered copy is low. Levels held high for many cycles act once.
- Reset (nRST=1 at a clk edge):
  - state=ENTER_A; operand A, operand B, op, result and display_output all 0; complete=0.
  - Edge-detect registers load 0.
  - Reset mid-operation, including during multiply, aborts with no residual state.
- ENTER_A:
  - Digit press with code 0-9: A <= A*10 + digit (mod 2^WIDTH); display_output <= new A.
  - Codes 10-15 are ignored unless the optional feature is enabled.
  - Operator press with exactly one bit set: latch op, B <= 0, display_output <= 0, go ENTER_B.
  - Non-one-hot operator values are ignored.
  - Equal press is ignored.
- ENTER_B:
  - Digits accumulate into B the same way; display_output <= B.
  - Further operator presses are ignored.
  - Equal press goes to EXEC.
- EXEC:
  - add: result = A+B, one cycle.
  - sub: result = A-B, one cycle.
  - mul: 16-iteration shift-add over B, one bit per cycle, keeping the low WIDTH bits of the product.
  - Inputs are ignored while in EXEC.
  - On finish: display_output <= result, complete <= 1, go DONE.
- Latency from the clk edge that captures the equal press (state enters EXEC) to complete=1:
  - add/sub: 1 cycle.
  - mul: 16 cycles.
- Overflow: no saturation and no flag; the result wraps. Examples: 128*256 -> 0x8000; 32767+1 -> 0x8000.
- DONE:
  - complete and display_output hold.
  - Digit press: A <= digit, B <= 0, complete <= 0, display_output <= digit, go ENTER_A.
  - Operator press: chains, A <= result, latch op, complete <= 0, go ENTER_B.
  - Equal press is ignored.
- Simultaneous presses in the same cycle are prioritised: equal > operator > digit; lower-priority presses that cycle are dropped.
- complete is 0 in every state except DONE.

Optional Feature:
- Macro GENCON_SIGN_KEY_EN.
- When defined: keypad code 4'hA pressed in ENTER_A or ENTER_B negates the current operand (two's complement). display_output updates the same cycle the press is captured. Code 4'hA in DONE negates the result and moves to ENTER_A with A = -result.
- When undefined: codes 10-15 are ignored everywhere; operands can only be entered as non-negative values (negative results still arise from subtraction and wrap).

Test Plan:
- Reset, digits 2, op 001, digit 3, equal -> complete=1 one cycle after EXEC entry; display_output=5.
- Digits 1,0,0,0, op 001, digits 2,3,4,5, equal -> 3345; display shows 1000 after A entry and 0 right after the operator press.
- Digit 3, op 010, digit 5, equal -> 0xFFFE (-2); digits 9,9, op 010, digit 0 -> 99.
- Digits 1,2,8, op 100, digits 2,5,6, equal -> complete exactly 16 cycles after EXEC entry; result 0x8000. 4*3 -> 12; 100*0 -> 0.
- Assert nRST during a multiply's 8th iteration -> next cycle complete=0, display_output=0, state ENTER_A; a fresh 2+3 then gives 5.
- With GENCON_SIGN_KEY_EN: digit 3, key A, op 100, digit 6, key A, equal -> 18. Digit 1, op 100, digit 1, key A -> 0xFFFF (-1). Holding equal_input high across DONE triggers no second computation.

Source files
------------

// File: rtl/gencon.sv
// Keypad calculator controller: decimal entry of two operands, add/sub/mul, result display.
// Optional GENCON_SIGN_KEY_EN: keypad code 4'hA negates the operand being entered.
module gencon #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic [3:0]       keypad_input,
  input  logic             read_input,
  input  logic [2:0]       operator_input,
  input  logic             equal_input,
  output logic             complete,
  output logic [WIDTH-1:0] display_output
);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a, b, result, mcand, mplier;
  logic [2:0]       op;
  logic [CW-1:0]    cnt;
  logic             read_q, op_q, eq_q;

  logic             eq_p, op_p, dig_p;
  logic             op_onehot, digit_ok, neg_key;
  logic [WIDTH-1:0] digit, a_next, b_next, sum, diff, mul_acc;

  // Press detection with fixed priority: equal > operator > digit.
  always_comb begin
    eq_p      = equal_input & ~eq_q;
    op_p      = (|operator_input) & ~op_q & ~eq_p;
    dig_p     = read_input & ~read_q & ~op_p & ~eq_p;
    op_onehot = (operator_input == 3'b001) || (operator_input == 3'b010) ||
                (operator_input == 3'b100);
    digit_ok  = (keypad_input <= 4'd9);
    digit     = WIDTH'(keypad_input);
    a_next    = a * WIDTH'(10) + digit;
    b_next    = b * WIDTH'(10) + digit;
    sum       = a + b;
    diff      = a - b;
    mul_acc   = result + (mplier[0] ? mcand : '0);
`ifdef GENCON_SIGN_KEY_EN
    neg_key   = (keypad_input == 4'hA);
`else
    neg_key   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      state          <= ENTER_A;
      a              <= '0;
      b              <= '0;
      result         <= '0;
      mcand          <= '0;
      mplier         <= '0;
      op             <= '0;
      cnt            <= '0;
      read_q         <= 1'b0;
      op_q           <= 1'b0;
      eq_q           <= 1'b0;
      complete       <= 1'b0;
      display_output <= '0;
    end else begin
      read_q <= read_input;
      op_q   <= |operator_input;
      eq_q   <= equal_input;
      case (state)
        ENTER_A: begin
          if (op_p && op_onehot) begin
            op             <= operator_input;
            b              <= '0;
            display_output <= '0;
            state          <= ENTER_B;
          end else if (dig_p && digit_ok) begin
            a              <= a_next;
            display_output <= a_next;
          end else if (dig_p && neg_key) begin
            a              <= -a;
            display_output <= -a;
          end
        end
        ENTER_B: begin
          if (eq_p) begin
            // Multiply works on copies so operands stay intact for debug.
            result <= '0;
            mcand  <= a;
            mplier <= b;
            cnt    <= '0;
            state  <= EXEC;
          end else if (dig_p && digit_ok) begin
            b              <= b_next;
            display_output <= b_next;
          end else if (dig_p && neg_key) begin
            b              <= -b;
            display_output <= -b;
          end
        end
        EXEC: begin
          if (op == 3'b100) begin
            result <= mul_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == CW'(WIDTH - 1)) begin
              display_output <= mul_acc;
              complete       <= 1'b1;
              state          <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            result         <= (op == 3'b010) ? diff : sum;
            display_output <= (op == 3'b010) ? diff : sum;
            complete       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (op_p && op_onehot) begin
            a              <= result;
            op             <= operator_input;
            b              <= '0;
            display_output <= '0;
            complete       <= 1'b0;
            state          <= ENTER_B;
          end else if (dig_p && digit_ok) begin
            a              <= digit;
            b              <= '0;
            display_output <= digit;
            complete       <= 1'b0;
            state          <= ENTER_A;
          end else if (dig_p && neg_key) begin
            a              <= -result;
            b              <= '0;
            display_output <= -result;
            complete       <= 1'b0;
            state          <= ENTER_A;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_gencon.sv
// Bench for gencon: table of calculations plus hand sequences for reset, chaining and held keys.
module tb_gencon;

  logic        clk;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  gencon #(.WIDTH(16)) dut (
    .clk            (clk),
    .nRST           (nRST),
    .keypad_input   (keypad_input),
    .read_input     (read_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .complete       (complete),
    .display_output (display_output)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b1;
    keypad_input = 4'd0; read_input = 1'b0; operator_input = 3'b000; equal_input = 1'b0;
    @(negedge clk);
    nRST = 1'b0;
  endtask

  // Driver tasks: each key is high for one cycle, low for one cycle.
  task automatic press_digit(input logic [3:0] d);
    @(negedge clk);
    keypad_input = d;
    read_input = 1'b1;
    @(negedge clk);
    read_input = 1'b0;
  endtask

  task automatic press_op(input logic [2:0] o);
    @(negedge clk);
    operator_input = o;
    @(negedge clk);
    operator_input = 3'b000;
  endtask

  task automatic enter_num(input int n);
    int d[6];
    int k;
    k = 0;
    do begin
      d[k] = n % 10;
      n = n / 10;
      k++;
    end while (n > 0);
    for (int i = k - 1; i >= 0; i--) press_digit(4'(d[i]));
  endtask

  // Scoreboard: expectation queued at equal press, popped when complete rises.
  task automatic do_equal(input logic [15:0] exp, input int lat, input bit hold, input string name);
    int cyc;
    bit seen;
    logic [15:0] e;
    @(negedge clk);
    equal_input = 1'b1;
    exp_q.push_back(exp);
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      if (!hold) equal_input = 1'b0;
      cyc++;
      if (complete) seen = 1;
    end
    check({name, "_complete"}, 32'(seen), 32'd1);
    if (seen) check({name, "_latency"}, 32'(cyc - 1), 32'(lat));
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_result"}, 32'(display_output), 32'(e));
    end
  endtask

  task automatic run_calc(input int a, input logic [2:0] o, input int b,
                          input logic [15:0] exp, input int lat, input string name);
    enter_num(a);
    press_op(o);
    enter_num(b);
    do_equal(exp, lat, 1'b0, name);
  endtask

  typedef struct {
    int          a;
    logic [2:0]  op;
    int          b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{a: 2,     op: 3'b001, b: 3,    exp: 16'd5,    lat: 1};
    vecs[1] = '{a: 1000,  op: 3'b001, b: 2345, exp: 16'd3345, lat: 1};
    vecs[2] = '{a: 3,     op: 3'b010, b: 5,    exp: 16'hFFFE, lat: 1};
    vecs[3] = '{a: 99,    op: 3'b010, b: 0,    exp: 16'd99,   lat: 1};
    vecs[4] = '{a: 128,   op: 3'b100, b: 256,  exp: 16'h8000, lat: 16};
    vecs[5] = '{a: 4,     op: 3'b100, b: 3,    exp: 16'd12,   lat: 16};
    vecs[6] = '{a: 100,   op: 3'b100, b: 0,    exp: 16'd0,    lat: 16};
    vecs[7] = '{a: 32767, op: 3'b001, b: 1,    exp: 16'h8000, lat: 1};
    vecs[8] = '{a: 7,     op: 3'b100, b: 9999, exp: 16'h1169, lat: 16};
    vecs[9] = '{a: 0,     op: 3'b010, b: 1,    exp: 16'hFFFF, lat: 1};

    nRST = 1'b1;
    keypad_input = 4'd0; read_input = 1'b0; operator_input = 3'b000; equal_input = 1'b0;
    repeat (2) @(negedge clk);
    nRST = 1'b0;
    check("reset_complete", 32'(complete), 32'd0);
    check("reset_display", 32'(display_output), 32'd0);
    check("reset_state", 32'(dut.state), 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_reset();
      run_calc(vecs[i].a, vecs[i].op, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Display during entry: A shown, then cleared on operator press.
    do_reset();
    enter_num(1000);
    check("entry_a_display", 32'(display_output), 32'd1000);
    press_op(3'b001);
    check("after_op_display", 32'(display_output), 32'd0);
    press_op(3'b100);
    enter_num(45);
    check("entry_b_display", 32'(display_output), 32'd45);
    do_equal(16'd1045, 1, 1'b0, "op_in_b_ignored");

    // Non-one-hot operator and codes above 9 are ignored in ENTER_A.
    do_reset();
    press_digit(4'd5);
    press_op(3'b011);
    check("bad_op_display", 32'(display_output), 32'd5);
    press_digit(4'd12);
    check("code12_ignored", 32'(display_output), 32'd5);
    press_digit(4'd2);
    check("still_enter_a", 32'(display_output), 32'd52);

    // Chaining from DONE, then a digit restarting entry.
    do_reset();
    run_calc(2, 3'b001, 3, 16'd5, 1, "chain_first");
    press_op(3'b010);
    check("chain_complete_low", 32'(complete), 32'd0);
    press_digit(4'd1);
    do_equal(16'd4, 1, 1'b0, "chain_second");
    press_digit(4'd7);
    check("done_digit_complete", 32'(complete), 32'd0);
    check("done_digit_display", 32'(display_output), 32'd7);
    press_op(3'b001);
    press_digit(4'd1);
    do_equal(16'd8, 1, 1'b0, "restart_calc");

    // Equal held high across DONE acts once; a fresh equal in DONE is ignored.
    do_reset();
    enter_num(2);
    press_op(3'b001);
    enter_num(3);
    do_equal(16'd5, 1, 1'b1, "held_equal");
    repeat (5) @(negedge clk);
    check("held_complete", 32'(complete), 32'd1);
    check("held_display", 32'(display_output), 32'd5);
    equal_input = 1'b0;
    @(negedge clk);
    equal_input = 1'b1;
    repeat (20) @(negedge clk);
    equal_input = 1'b0;
    check("done_eq_complete", 32'(complete), 32'd1);
    check("done_eq_display", 32'(display_output), 32'd5);

    // Reset during the 8th multiply iteration aborts completely.
    do_reset();
    enter_num(128);
    press_op(3'b100);
    enter_num(256);
    @(negedge clk);
    equal_input = 1'b1;
    @(negedge clk);
    equal_input = 1'b0;
    repeat (7) @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);
    nRST = 1'b0;
    check("abort_complete", 32'(complete), 32'd0);
    check("abort_display", 32'(display_output), 32'd0);
    check("abort_state", 32'(dut.state), 32'd0);
    repeat (20) @(negedge clk);
    check("abort_no_late_done", 32'(complete), 32'd0);
    run_calc(2, 3'b001, 3, 16'd5, 1, "after_abort");

`ifdef GENCON_SIGN_KEY_EN
    do_reset();
    press_digit(4'd3);
    press_digit(4'hA);
    check("neg_a_display", 32'(display_output), 32'hFFFD);
    press_op(3'b100);
    press_digit(4'd6);
    press_digit(4'hA);
    check("neg_b_display", 32'(display_output), 32'hFFFA);
    do_equal(16'd18, 16, 1'b0, "neg_mul");
    do_reset();
    press_digit(4'd1);
    press_op(3'b100);
    press_digit(4'd1);
    press_digit(4'hA);
    do_equal(16'hFFFF, 16, 1'b0, "neg_one");
    press_digit(4'hA);
    check("neg_done_display", 32'(display_output), 32'd1);
    check("neg_done_complete", 32'(complete), 32'd0);
`else
    do_reset();
    press_digit(4'd4);
    press_digit(4'hA);
    check("key_a_ignored", 32'(display_output), 32'd4);
`endif

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
